// File: rtl/oam_line_evaluator.sv
// Per-scanline sprite evaluator: sweeps OAM during hblank and builds the line sprite list.
// Optional OAM_EVAL_OVF_EN: full sweep with overflow detection; otherwise the sweep stops once the list fills.
module oam_line_evaluator #(
    parameter int unsigned NUM_ENTRIES = 256,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MAX_SPRITES = 8,
    parameter int unsigned SPRITE_H    = 32,
    localparam int unsigned LW         = $clog2(MAX_SPRITES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [8:0]        line,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] oam_addr,
    output logic              oam_rw,
    input  logic [31:0]       oam_rdata,
    output logic              list_we,
    output logic [LW-1:0]     list_addr,
    output logic [31:0]       list_wdata,
    output logic [4:0]        list_row,
    output logic [LW:0]       sprite_count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINISH
    } state_t;

    state_t            state_q;
    logic [8:0]        line_q;
    logic [LW:0]       hits_q;
    logic              issue_q;
    logic              valid_q;
    logic              last_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] oam_addr_q;
    logic              list_we_q;
    logic [LW-1:0]     list_addr_q;
    logic [31:0]       list_wdata_q;
    logic [4:0]        list_row_q;
    logic [LW:0]       sprite_count_q;
`ifdef OAM_EVAL_OVF_EN
    logic              ovf_q;
    logic              overflow_q;
`endif

    logic [9:0] diff_d;
    logic       hit_d;
    logic       room_d;
    logic       last_addr_d;

    // Data on oam_rdata belongs to the address issued one clock earlier; valid_q marks it.
    always_comb begin
        diff_d      = {1'b0, line_q} - {1'b0, oam_rdata[18:10]};
        hit_d       = valid_q && oam_rdata[31] && (line_q >= oam_rdata[18:10])
                      && (diff_d < 10'(SPRITE_H));
        room_d      = hits_q < (LW+1)'(MAX_SPRITES);
        last_addr_d = oam_addr_q == ADDR_W'(NUM_ENTRIES - 1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            line_q         <= '0;
            hits_q         <= '0;
            issue_q        <= 1'b0;
            valid_q        <= 1'b0;
            last_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            oam_addr_q     <= '0;
            list_we_q      <= 1'b0;
            list_addr_q    <= '0;
            list_wdata_q   <= '0;
            list_row_q     <= '0;
            sprite_count_q <= '0;
`ifdef OAM_EVAL_OVF_EN
            ovf_q          <= 1'b0;
            overflow_q     <= 1'b0;
`endif
        end else begin
            list_we_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        line_q     <= line;
                        hits_q     <= '0;
                        oam_addr_q <= '0;
                        issue_q    <= 1'b1;
                        valid_q    <= 1'b0;
                        last_q     <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef OAM_EVAL_OVF_EN
                        ovf_q      <= 1'b0;
`endif
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    valid_q <= issue_q;
                    last_q  <= issue_q && last_addr_d;
                    if (issue_q) begin
                        if (last_addr_d) begin
                            issue_q <= 1'b0;
                        end else begin
                            oam_addr_q <= oam_addr_q + 1'b1;
                        end
                    end
                    if (hit_d && room_d) begin
                        list_we_q    <= 1'b1;
                        list_addr_q  <= hits_q[LW-1:0];
                        list_wdata_q <= oam_rdata;
                        list_row_q   <= diff_d[4:0];
                        hits_q       <= hits_q + 1'b1;
                    end
                    if (valid_q && last_q) begin
                        state_q <= FINISH;
                    end
`ifdef OAM_EVAL_OVF_EN
                    if (hit_d && !room_d) begin
                        ovf_q <= 1'b1;
                    end
`else
                    // Filling the last slot ends the sweep; the read still in flight is dropped.
                    if (hit_d && hits_q == (LW+1)'(MAX_SPRITES - 1)) begin
                        issue_q <= 1'b0;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        state_q <= FINISH;
                    end
`endif
                end
                FINISH: begin
                    sprite_count_q <= hits_q;
`ifdef OAM_EVAL_OVF_EN
                    overflow_q     <= ovf_q;
`endif
                    done_q         <= 1'b1;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign oam_addr     = oam_addr_q;
    assign oam_rw       = 1'b0;
    assign list_we      = list_we_q;
    assign list_addr    = list_addr_q;
    assign list_wdata   = list_wdata_q;
    assign list_row     = list_row_q;
    assign sprite_count = sprite_count_q;
`ifdef OAM_EVAL_OVF_EN
    assign overflow     = overflow_q;
`else
    assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_oam_line_evaluator.sv
// Self-checking bench for oam_line_evaluator: directed cases plus random OAM contents
// checked against a list-building reference model; honours OAM_EVAL_OVF_EN.
module tb_oam_line_evaluator;

    localparam int N   = 256;
    localparam int AW  = 8;
    localparam int MAX = 8;
    localparam int SH  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [8:0]    line;
    logic          busy;
    logic          done;
    logic [AW-1:0] oam_addr;
    logic          oam_rw;
    logic [31:0]   oam_rdata;
    logic          list_we;
    logic [2:0]    list_addr;
    logic [31:0]   list_wdata;
    logic [4:0]    list_row;
    logic [3:0]    sprite_count;
    logic          overflow;

    oam_line_evaluator #(
        .NUM_ENTRIES(N),
        .ADDR_W     (AW),
        .MAX_SPRITES(MAX),
        .SPRITE_H   (SH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .line        (line),
        .busy        (busy),
        .done        (done),
        .oam_addr    (oam_addr),
        .oam_rw      (oam_rw),
        .oam_rdata   (oam_rdata),
        .list_we     (list_we),
        .list_addr   (list_addr),
        .list_wdata  (list_wdata),
        .list_row    (list_row),
        .sprite_count(sprite_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    logic [31:0] oam [N];
    always @(posedge clk) oam_rdata <= oam[oam_addr];

    int checks   = 0;
    int failures = 0;

    int          exp_idx[$];
    int          cap_addr[$];
    logic [31:0] cap_data[$];
    int          cap_row[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: every enabled sprite whose span covers the line, in OAM order.
    task automatic model(input logic [8:0] ln);
        int d;
        exp_idx.delete();
        for (int i = 0; i < N; i++) begin
            d = int'(ln) - int'(oam[i][18:10]);
            if (oam[i][31] && d >= 0 && d < SH) exp_idx.push_back(i);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_oam_addr"}, oam_addr, 0);
        chk({tag, "_oam_rw"}, oam_rw, 0);
        chk({tag, "_list_we"}, list_we, 0);
        chk({tag, "_list_addr"}, list_addr, 0);
        chk({tag, "_list_wdata"}, list_wdata, 0);
        chk({tag, "_list_row"}, list_row, 0);
        chk({tag, "_sprite_count"}, sprite_count, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic run(input logic [8:0] ln, input int restart_at, input int reset_at,
                       output int done_edge);
        int m;
        cap_addr.delete();
        cap_data.delete();
        cap_row.delete();
        done_edge = -1;
        @(negedge clk);
        line  = ln;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        m = 0;
        while (m < 400) begin
            @(negedge clk);
            if (list_we) begin
                cap_addr.push_back(int'(list_addr));
                cap_data.push_back(list_wdata);
                cap_row.push_back(int'(list_row));
            end
            if (done) begin
                done_edge = m;
                break;
            end
            chk("busy_during_sweep", busy, 1);
            chk("oam_rw_read", oam_rw, 0);
            if (m == reset_at) begin
                reset = 1'b0;
                #1 check_reset_outputs("midreset");
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (m == restart_at) begin
                start = 1'b1;
                line  = 9'd7;
            end
            @(posedge clk);
            #1 start = 1'b0;
            m++;
        end
        if (done_edge < 0) begin
            chk("done_timeout", done, 1);
        end else begin
            chk("busy_at_done", busy, 0);
            @(negedge clk);
            chk("done_single_pulse", done, 0);
            chk("list_we_after_done", list_we, 0);
        end
    endtask

    task automatic check_run(input string tag, input logic [8:0] ln, input int done_edge);
        int nh, ns, exp_done, exp_ovf, n;
        model(ln);
        nh = exp_idx.size();
        ns = (nh < MAX) ? nh : MAX;
`ifdef OAM_EVAL_OVF_EN
        exp_done = N + 2;
        exp_ovf  = (nh > MAX) ? 1 : 0;
`else
        exp_done = (nh >= MAX) ? exp_idx[MAX-1] + 3 : N + 2;
        exp_ovf  = 0;
`endif
        chk({tag, "_done_latency"}, done_edge, exp_done);
        chk({tag, "_list_writes"}, cap_addr.size(), ns);
        n = (cap_addr.size() < ns) ? cap_addr.size() : ns;
        for (int j = 0; j < n; j++) begin
            chk({tag, "_slot"}, cap_addr[j], j);
            chk({tag, "_wdata"}, cap_data[j], oam[exp_idx[j]]);
            chk({tag, "_row"}, cap_row[j], int'(ln) - int'(oam[exp_idx[j]][18:10]));
        end
        chk({tag, "_sprite_count"}, sprite_count, ns);
        chk({tag, "_overflow"}, overflow, exp_ovf);
    endtask

    task automatic clear_oam();
        for (int i = 0; i < N; i++) oam[i] = $urandom & 32'h7fff_ffff;
    endtask

    task automatic set_entry(input int i, input logic [8:0] y);
        logic [31:0] e;
        e = $urandom;
        e[31] = 1'b1;
        e[18:10] = y;
        oam[i] = e;
    endtask

    task automatic random_oam();
        logic [31:0] e;
        for (int i = 0; i < N; i++) begin
            e = $urandom;
            e[31] = ($urandom_range(0, 3) == 0);
            e[18:10] = 9'($urandom_range(0, 300));
            oam[i] = e;
        end
    endtask

    initial begin
        int de;
        logic [8:0] ln;
        reset = 1'b0;
        start = 1'b0;
        line  = '0;
        for (int i = 0; i < N; i++) oam[i] = '0;
        #23 check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // All disabled
        clear_oam();
        run(9'd100, -1, -1, de);
        check_run("alloff", 9'd100, de);
        chk("alloff_latency_258", de, 258);

        // Single sprite, top/bottom/beyond rows
        set_entry(5, 9'd100);
        run(9'd100, -1, -1, de);
        check_run("e5_l100", 9'd100, de);
        chk("e5_l100_row0", cap_row.size() > 0 ? cap_row[0] : -1, 0);
        run(9'd131, -1, -1, de);
        check_run("e5_l131", 9'd131, de);
        chk("e5_l131_row31", cap_row.size() > 0 ? cap_row[0] : -1, 31);
        run(9'd132, -1, -1, de);
        check_run("e5_l132", 9'd132, de);

        // No vertical wrap
        clear_oam();
        set_entry(0, 9'd470);
        run(9'd5, -1, -1, de);
        check_run("nowrap_l5", 9'd5, de);
        run(9'd479, -1, -1, de);
        check_run("y470_l479", 9'd479, de);
        chk("y470_l479_row9", cap_row.size() > 0 ? cap_row[0] : -1, 9);

        // Ten hits on one line
        clear_oam();
        for (int i = 0; i < 10; i++) set_entry(i, 9'(50 - 2 * i));
        run(9'd50, -1, -1, de);
        check_run("tenhits", 9'd50, de);

        // Restart pulse ignored mid-sweep
        random_oam();
        run(9'd60, 20, -1, de);
        check_run("restart_ignored", 9'd60, de);

        // Reset mid-sweep, then clean sweep
        random_oam();
        run(9'd120, -1, 40, de);
        run(9'd120, -1, -1, de);
        check_run("after_reset", 9'd120, de);

        // Random OAM contents and lines
        for (int t = 0; t < 6; t++) begin
            random_oam();
            ln = 9'($urandom_range(0, 335));
            run(ln, -1, -1, de);
            check_run("random", ln, de);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oam_line_evaluator.md
Name: oam_line_evaluator

Overview:
- Per-scanline sprite evaluator. During horizontal blank it sequences a full read sweep of OAM through one OAM read port.
- Selects every enabled sprite that covers the requested scanline and writes up to MAX_SPRITES hits, in OAM index order, into the line sprite list consumed by the sprite pixel pipeline.
- Sole master of its OAM port; never writes OAM.

Parameters:
- NUM_ENTRIES, 256, number of OAM entries swept; power of 2, at most 2^ADDR_W.
- ADDR_W, 8, OAM address width.
- MAX_SPRITES, 8, line list depth; power of 2.
- SPRITE_H, 32, sprite height in lines; power of 2, at most 32.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begin evaluating `line`.
- line  in  9  target scanline; sampled when start is accepted.
- busy  out  1  evaluation in progress.
- done  out  1  single-cycle completion pulse.
- oam_addr  out  ADDR_W  OAM read address.
- oam_rw  out  1  OAM read/write select; constant 0 (read).
- oam_rdata  in  32  OAM read data; registered, valid one clock after oam_addr.
- list_we  out  1  line list write strobe.
- list_addr  out  log2(MAX_SPRITES)  line list slot.
- list_wdata  out  32  OAM entry copied unchanged.
- list_row  out  5  row within the sprite (line - y).
- sprite_count  out  log2(MAX_SPRITES)+1  hits stored in the last evaluation.
- overflow  out  1  more than MAX_SPRITES hits on the line.

Behaviour:
- OAM entry format:
  - [31] enable
  - [30:27] pattern
  - [26:24] palette
  - [23:19] reserved
  - [18:10] y (top line)
  - [9:0] x
- Hit condition: enable=1 and line >= y and (line - y) < SPRITE_H. Compare in 10-bit unsigned arithmetic. There is no vertical wrap: y=470 never hits line 5.
- Reset (reset low, asynchronous): state IDLE. busy=0, done=0, oam_addr=0, list_we=0, list_addr=0, list_wdata=0, list_row=0, sprite_count=0, overflow=0. Reset mid-sweep abandons the sweep; any partial list contents are don't-care.
- State IDLE:
  - start=1: latch line; clear the hit counter and internal overflow; oam_addr<=0; busy<=1; go to SCAN.
  - start=0: remain.
- State SCAN:
  - oam_addr increments by 1 per clock through NUM_ENTRIES-1.
  - A one-bit valid pipeline tracks the read latency. Entry k is evaluated the clock after address k is presented.
  - On a hit with hits < MAX_SPRITES: registered list_we=1 for one clock, list_addr=hits, list_wdata=entry, list_row=(line - y)[4:0]; hits++.
  - On a hit with hits == MAX_SPRITES: internal overflow<=1.
  - Move to FINISH when the last entry has been evaluated, or under the early-stop rule in Optional Feature.
- State FINISH (one clock): sprite_count<=hits, overflow<=internal overflow, done=1, busy<=0; go to IDLE. sprite_count and overflow hold until the next FINISH.
- Latency: full sweep with start accepted at edge 0 gives last list write at edge NUM_ENTRIES+1 and done high for the clock following edge NUM_ENTRIES+2. busy is high over the same span up to done.
- start while busy or in FINISH: ignored; line is not relatched.
- list_we never asserts outside SCAN. At most MAX_SPRITES writes per evaluation, to slots 0..hits-1 in ascending OAM order.

Optional Feature:
- Macro: OAM_EVAL_OVF_EN.
- Defined: the sweep always covers all NUM_ENTRIES entries. After the list is full, further hits set overflow and no longer write the list. Timing is always a full sweep.
- Undefined:
  - When the MAX_SPRITES-th hit is written, address issue stops. The in-flight read is discarded and the next clock is FINISH.
  - overflow is tied 0.
  - done arrives early.

Test Plan:
- All entries enable=0, start with line=100 -> no list_we; done exactly NUM_ENTRIES+2 clocks after start (258 with defaults); sprite_count=0, overflow=0.
- Entry 5 = {en=1, y=100}, line=100 / 131 / 132 -> hit list_row=0 / hit list_row=31 / no hit; each hit has list_addr=0, list_wdata equal to entry 5, sprite_count=1.
- Entry 0 = {en=1, y=470}, line=5 -> no hit (no wrap). Same entry, line=479 -> hit with list_row=9.
- Entries 0..9 all hit line 50:
  - OAM_EVAL_OVF_EN defined -> slots 0..7 hold entries 0..7, sprite_count=8, overflow=1, done at 258.
  - Undefined -> sprite_count=8, overflow=0, done at 10 clocks after start.
- start pulsed again at clock 20 of a sweep with line=7 -> ignored; results reflect the original line; busy stays continuous.
- reset asserted at clock 40 of a sweep -> all outputs immediately at reset values. A subsequent start -> clean full sweep with correct results.
